// File: rtl/weight_instr_sequencer_pkg.sv
// weight_instr_sequencer_pkg: instruction record and sequencer state encoding shared by the weight sequencer slice
package weight_instr_sequencer_pkg;
  localparam int ADDR_W = 32;
  localparam int CNT_W = 16;
  typedef struct packed {
    logic [ADDR_W-1:0] weight_addr;
    logic [ADDR_W-1:0] stride;
    logic [CNT_W-1:0] burst_count;
    logic [CNT_W-1:0] burst_len;
  } instruction_weight_t;
  typedef enum logic [1:0] {WS_IDLE, WS_WAIT, WS_ISSUE} weight_seq_state_e;
endpackage

// File: rtl/weight_instr_sequencer_if.sv
// weight_instr_sequencer_if: instruction FIFO read port plus burst request stream to the weight loader
interface weight_instr_sequencer_if import weight_instr_sequencer_pkg::*;;
  instruction_weight_t fifo_dout;
  logic fifo_empty;
  logic fifo_rd_en;
  logic req_valid;
  logic req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [CNT_W-1:0] req_len;
  logic req_last;
  modport master (input fifo_dout, fifo_empty, req_ready, output fifo_rd_en, req_valid, req_addr, req_len, req_last);
  modport slave (output fifo_dout, fifo_empty, req_ready, input fifo_rd_en, req_valid, req_addr, req_len, req_last);
endinterface

// File: rtl/weight_instr_sequencer.sv
// weight_instr_sequencer: pops weight instructions and expands each into strided burst requests
module weight_instr_sequencer import weight_instr_sequencer_pkg::*; #(
  parameter int FIFO_RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  weight_instr_sequencer_if.master bus,
  output logic busy,
  output logic instr_done,
  output logic [31:0] instr_count
);
  weight_seq_state_e state, state_n;
  logic [ADDR_W-1:0] cur_addr, stride_q;
  logic [CNT_W-1:0] remain, len_q;
  logic cap, zero, fire, last_fire, done_set;
  instruction_weight_t din;
  assign din = bus.fifo_dout;
  // rst gating keeps the pop strobe quiet while the async reset is held
  assign bus.fifo_rd_en = state == WS_IDLE && !bus.fifo_empty && !rst;
  assign bus.req_valid = state == WS_ISSUE;
  assign bus.req_addr = cur_addr;
  assign bus.req_len = len_q;
  assign bus.req_last = bus.req_valid && remain == CNT_W'(1);
  assign busy = state != WS_IDLE;
  assign cap = FIFO_RD_LAT == 0 ? bus.fifo_rd_en : state == WS_WAIT;
  assign zero = din.burst_count == '0;
  assign fire = bus.req_valid && bus.req_ready;
  assign last_fire = fire && bus.req_last;
  assign done_set = last_fire || (cap && zero);
  always_comb begin
    state_n = state;
    state_n = cap ? (zero ? WS_IDLE : WS_ISSUE)
            : bus.fifo_rd_en ? WS_WAIT
            : last_fire ? WS_IDLE
            : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= WS_IDLE;
      cur_addr <= '0;
      stride_q <= '0;
      remain <= '0;
      len_q <= '0;
      instr_done <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_n;
      instr_done <= done_set;
      if (done_set) instr_count <= instr_count + 32'd1;
      if (cap) begin
        cur_addr <= din.weight_addr;
        stride_q <= din.stride;
        remain <= din.burst_count;
        len_q <= din.burst_len;
      end else if (fire) begin
        cur_addr <= cur_addr + stride_q;
        remain <= remain - CNT_W'(1);
      end
    end
endmodule
